// File: rtl/sindoku_pkg.sv
// Shared constants, one-hot state encoding and the board address helper for
// the Sudoku game sequencer.
//   GRID/CELLS : board side and cell count (only 9x9 is supported)
//   AW/DW      : board/ROM address width and digit width (0 = empty cell)
//   state_t    : one-hot sequencer states I, LOAD, SOLVE, CHECK, CORRECT, INCORRECT
//   rc2addr    : linear cell address row*9 + col
package sindoku_pkg;

    localparam int GRID  = 9;
    localparam int CELLS = GRID * GRID;
    localparam int AW    = 7;
    localparam int DW    = 4;

    localparam logic [3:0]    POS_MAX   = 4'd8;
    localparam logic [AW-1:0] LAST_ADDR = 7'd80;
    localparam logic [DW-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [5:0] {
        ST_I         = 6'b000001,
        ST_LOAD      = 6'b000010,
        ST_SOLVE     = 6'b000100,
        ST_CHECK     = 6'b001000,
        ST_CORRECT   = 6'b010000,
        ST_INCORRECT = 6'b100000
    } state_t;

    // Operands are widened before the multiply so row*9 does not truncate.
    function automatic logic [AW-1:0] rc2addr(input logic [3:0] row, input logic [3:0] col);
        return ({3'b000, row} * 7'd9) + {3'b000, col};
    endfunction

endpackage

// File: rtl/sindoku_game_ctrl_if.sv
// Memory-side bus of the game sequencer: the shared combinational puzzle /
// solution ROM address and the single-port board RAM.
//   rom_addr  : address to both ROMs        puz_data/sol_data : ROM digits
//   brd_addr  : board RAM address           brd_we/brd_wdata  : write port
//   brd_rdata : board RAM read data, one-cycle latency
// master = sequencer side, slave = memory side.
interface sindoku_game_ctrl_if;
    import sindoku_pkg::*;

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] puz_data;
    logic [DW-1:0] sol_data;
    logic [AW-1:0] brd_addr;
    logic          brd_we;
    logic [DW-1:0] brd_wdata;
    logic [DW-1:0] brd_rdata;

    modport master (
        output rom_addr, brd_addr, brd_we, brd_wdata,
        input  puz_data, sol_data, brd_rdata
    );

    modport slave (
        input  rom_addr, brd_addr, brd_we, brd_wdata,
        output puz_data, sol_data, brd_rdata
    );

endinterface

// File: rtl/sindoku_cursor.sv
// Board cursor: row/col registers with clamped single-step moves.
//   Clk, Reset          : clock, async active-high reset (cursor -> 0,0)
//   move_en             : moves are honoured only when set
//   BtnR/BtnL/BtnU/BtnD : move pulses, priority R > L > U > D
//   load_en/load_row/load_col : jump to a given cell (overrides moves)
//   row, col            : registered cursor position 0..8
//   addr                : combinational linear address of the cursor
module sindoku_cursor
    import sindoku_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          move_en,
    input  logic          BtnR,
    input  logic          BtnL,
    input  logic          BtnU,
    input  logic          BtnD,
    input  logic          load_en,
    input  logic [3:0]    load_row,
    input  logic [3:0]    load_col,
    output logic [3:0]    row,
    output logic [3:0]    col,
    output logic [AW-1:0] addr
);

    logic [3:0] row_r;
    logic [3:0] col_r;
    logic [3:0] row_nxt_s;
    logic [3:0] col_nxt_s;

    // Next cursor position: load wins, then one clamped move by priority.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (load_en) begin
            row_nxt_s = load_row;
            col_nxt_s = load_col;
        end else if (move_en) begin
            if (BtnR) begin
                col_nxt_s = (col_r < POS_MAX) ? col_r + 4'd1 : col_r;
            end else if (BtnL) begin
                col_nxt_s = (col_r > 4'd0) ? col_r - 4'd1 : col_r;
            end else if (BtnU) begin
                row_nxt_s = (row_r > 4'd0) ? row_r - 4'd1 : row_r;
            end else if (BtnD) begin
                row_nxt_s = (row_r < POS_MAX) ? row_r + 4'd1 : row_r;
            end else begin
                row_nxt_s = row_r;
                col_nxt_s = col_r;
            end
        end else begin
            row_nxt_s = row_r;
            col_nxt_s = col_r;
        end
    end

    // Cursor position register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row_r <= 4'd0;
            col_r <= 4'd0;
        end else begin
            row_r <= row_nxt_s;
            col_r <= col_nxt_s;
        end
    end

    assign row  = row_r;
    assign col  = col_r;
    assign addr = rc2addr(row_r, col_r);

endmodule

// File: rtl/sindoku_game_ctrl.sv
// Sudoku game sequencer: loads the puzzle into the board RAM, lets the user
// move a cursor and commit digits into non-fixed cells, and scans the board
// against the solution ROM reporting correct or the first wrong cell.
//   Clk, Reset          : clock, async active-high reset
//   BtnR/L/U/D/C        : debounced pulses (move, commit)
//   CheckSolu, Ack      : start check scan, acknowledge result
//   UserIn              : digit to commit (0 clears, >9 rejected)
//   bus                 : ROM/board RAM bus (master side)
//   CurRow/CurCol       : registered cursor position
//   ErrRow/ErrCol       : registered first mismatch of the last check
//   q_*                 : one-hot state outputs
module sindoku_game_ctrl
    import sindoku_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 BtnR,
    input  logic                 BtnL,
    input  logic                 BtnU,
    input  logic                 BtnD,
    input  logic                 BtnC,
    input  logic                 CheckSolu,
    input  logic                 Ack,
    input  logic [DW-1:0]        UserIn,
    sindoku_game_ctrl_if.master  bus,
    output logic [3:0]           CurRow,
    output logic [3:0]           CurCol,
    output logic [3:0]           ErrRow,
    output logic [3:0]           ErrCol,
    output logic                 q_I,
    output logic                 q_Load,
    output logic                 q_Solve,
    output logic                 q_Check,
    output logic                 q_Correct,
    output logic                 q_Incorrect
);

    state_t           state_r;
    state_t           next_state_s;
    logic [AW-1:0]    cnt_r;
    logic [3:0]       scan_row_r;
    logic [3:0]       scan_col_r;
    logic             cmp_vld_r;
    logic [AW-1:0]    cmp_addr_r;
    logic [3:0]       cmp_row_r;
    logic [3:0]       cmp_col_r;
    logic [DW-1:0]    sol_r;
    logic [CELLS-1:0] fixed_r;
    logic [3:0]       err_row_r;
    logic [3:0]       err_col_r;

    logic [AW-1:0]    cur_addr_s;
    logic [3:0]       cur_row_s;
    logic [3:0]       cur_col_s;
    logic             move_en_s;
    logic             load_cur_s;
    logic             issue_s;
    logic             mismatch_s;
    logic             commit_ok_s;
    logic             err_cap_s;
    logic [AW-1:0]    rom_addr_s;
    logic [AW-1:0]    brd_addr_s;
    logic             brd_we_s;
    logic [DW-1:0]    brd_wdata_s;

    sindoku_cursor u_cursor (
        .Clk      (Clk),
        .Reset    (Reset),
        .move_en  (move_en_s),
        .BtnR     (BtnR),
        .BtnL     (BtnL),
        .BtnU     (BtnU),
        .BtnD     (BtnD),
        .load_en  (load_cur_s),
        .load_row (err_row_r),
        .load_col (err_col_r),
        .row      (cur_row_s),
        .col      (cur_col_s),
        .addr     (cur_addr_s)
    );

    // A check cycle issues an address only while the scan is inside the board;
    // the compare stage sees the RAM word one cycle later.
    assign issue_s     = (state_r == ST_CHECK) && (cnt_r <= LAST_ADDR);
    assign mismatch_s  = (bus.brd_rdata == 4'd0) || (bus.brd_rdata != sol_r);
    assign commit_ok_s = (fixed_r[cur_addr_s] == 1'b0) && (UserIn <= MAX_DIGIT);
    assign err_cap_s   = (state_r == ST_CHECK) && cmp_vld_r && mismatch_s;

    // Next state and combinational memory-bus drive.
    always_comb begin
        next_state_s = state_r;
        rom_addr_s   = cur_addr_s;
        brd_addr_s   = cur_addr_s;
        brd_we_s     = 1'b0;
        brd_wdata_s  = UserIn;
        move_en_s    = 1'b0;
        load_cur_s   = 1'b0;
        case (state_r)
            ST_I: begin
                next_state_s = ST_LOAD;
            end
            ST_LOAD: begin
                rom_addr_s  = cnt_r;
                brd_addr_s  = cnt_r;
                brd_we_s    = 1'b1;
                brd_wdata_s = bus.puz_data;
                if (cnt_r == LAST_ADDR) begin
                    next_state_s = ST_SOLVE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_SOLVE: begin
                if (CheckSolu) begin
                    next_state_s = ST_CHECK;
                end else if (BtnC) begin
                    brd_we_s = commit_ok_s;
                end else begin
                    move_en_s = 1'b1;
                end
            end
            ST_CHECK: begin
                rom_addr_s = issue_s ? cnt_r : 7'd0;
                brd_addr_s = issue_s ? cnt_r : 7'd0;
                if (cmp_vld_r && mismatch_s) begin
                    next_state_s = ST_INCORRECT;
                end else if (cmp_vld_r && (cmp_addr_r == LAST_ADDR)) begin
                    next_state_s = ST_CORRECT;
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
            ST_CORRECT: begin
                if (Ack) begin
                    next_state_s = ST_I;
                end else begin
                    next_state_s = ST_CORRECT;
                end
            end
            ST_INCORRECT: begin
                if (Ack) begin
                    next_state_s = ST_SOLVE;
                    load_cur_s   = 1'b1;
                end else begin
                    next_state_s = ST_INCORRECT;
                end
            end
            default: begin
                next_state_s = ST_I;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_I;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Shared load/scan counter plus row/col of the scan address; cleared in I
    // and SOLVE so LOAD and CHECK both start from cell 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_r      <= 7'd0;
            scan_row_r <= 4'd0;
            scan_col_r <= 4'd0;
        end else if ((state_r == ST_I) || (state_r == ST_SOLVE)) begin
            cnt_r      <= 7'd0;
            scan_row_r <= 4'd0;
            scan_col_r <= 4'd0;
        end else if ((state_r == ST_LOAD) || issue_s) begin
            cnt_r <= cnt_r + 7'd1;
            if (scan_col_r == POS_MAX) begin
                scan_col_r <= 4'd0;
                scan_row_r <= scan_row_r + 4'd1;
            end else begin
                scan_col_r <= scan_col_r + 4'd1;
            end
        end else begin
            cnt_r      <= cnt_r;
            scan_row_r <= scan_row_r;
            scan_col_r <= scan_col_r;
        end
    end

    // Check pipeline stage 1: latch solution digit and the issued cell.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cmp_vld_r  <= 1'b0;
            cmp_addr_r <= 7'd0;
            cmp_row_r  <= 4'd0;
            cmp_col_r  <= 4'd0;
            sol_r      <= 4'd0;
        end else begin
            cmp_vld_r  <= issue_s;
            cmp_addr_r <= cnt_r;
            cmp_row_r  <= scan_row_r;
            cmp_col_r  <= scan_col_r;
            sol_r      <= bus.sol_data;
        end
    end

    // Fixed-cell mask, rebuilt while the puzzle is loaded.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fixed_r <= {CELLS{1'b0}};
        end else if (state_r == ST_LOAD) begin
            fixed_r[cnt_r] <= (bus.puz_data != 4'd0);
        end else begin
            fixed_r <= fixed_r;
        end
    end

    // First-mismatch coordinates of the last check.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_row_r <= 4'd0;
            err_col_r <= 4'd0;
        end else if (err_cap_s) begin
            err_row_r <= cmp_row_r;
            err_col_r <= cmp_col_r;
        end else begin
            err_row_r <= err_row_r;
            err_col_r <= err_col_r;
        end
    end

    assign bus.rom_addr  = rom_addr_s;
    assign bus.brd_addr  = brd_addr_s;
    assign bus.brd_we    = brd_we_s;
    assign bus.brd_wdata = brd_wdata_s;

    assign CurRow      = cur_row_s;
    assign CurCol      = cur_col_s;
    assign ErrRow      = err_row_r;
    assign ErrCol      = err_col_r;
    assign q_I         = state_r[0];
    assign q_Load      = state_r[1];
    assign q_Solve     = state_r[2];
    assign q_Check     = state_r[3];
    assign q_Correct   = state_r[4];
    assign q_Incorrect = state_r[5];

endmodule

// File: tb/tb_sindoku_game_ctrl.sv
// Scoreboard bench for sindoku_game_ctrl: stimulus pushes expected board
// commits and expected state entries into queues; a negedge monitor pops and
// compares them whenever the DUT writes in SOLVE or changes state.
module tb_sindoku_game_ctrl;
    import sindoku_pkg::*;

    localparam logic [6:0] P_R   = 7'b0000001;
    localparam logic [6:0] P_L   = 7'b0000010;
    localparam logic [6:0] P_U   = 7'b0000100;
    localparam logic [6:0] P_D   = 7'b0001000;
    localparam logic [6:0] P_C   = 7'b0010000;
    localparam logic [6:0] P_CHK = 7'b0100000;
    localparam logic [6:0] P_ACK = 7'b1000000;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int st; int lat; bit chk_err; int er; int ec; bit chk_cur; int cr; int cc; } st_exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BtnR = 1'b0, BtnL = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0;
    logic CheckSolu = 1'b0, Ack = 1'b0;
    logic [3:0] UserIn = 4'd0;
    logic [3:0] CurRow, CurCol, ErrRow, ErrCol;
    logic q_I, q_Load, q_Solve, q_Check, q_Correct, q_Incorrect;
    logic [5:0] st_vec;
    logic [3:0] ram [0:80];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwr = 0;
    wr_t wr_q[$];
    st_exp_t st_q[$];

    sindoku_game_ctrl_if bif ();

    sindoku_game_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .BtnR(BtnR), .BtnL(BtnL), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .CheckSolu(CheckSolu), .Ack(Ack), .UserIn(UserIn),
        .bus(bif.master),
        .CurRow(CurRow), .CurCol(CurCol), .ErrRow(ErrRow), .ErrCol(ErrCol),
        .q_I(q_I), .q_Load(q_Load), .q_Solve(q_Solve), .q_Check(q_Check),
        .q_Correct(q_Correct), .q_Incorrect(q_Incorrect)
    );

    always #5 Clk = ~Clk;

    assign st_vec = {q_Incorrect, q_Correct, q_Check, q_Solve, q_Load, q_I};

    // Valid Sudoku solution (shifted pattern); cell 1 holds 5, cell 40 holds 3.
    function automatic int sol_dig(input int a);
        int r = a / 9;
        int c = a % 9;
        return ((r * 3 + r / 3 + c + 3) % 9) + 1;
    endfunction

    // Puzzle gives the cells with (row+col)%3==1; cell 0 and cell 40 are blank.
    function automatic int puz_dig(input int a);
        int r = a / 9;
        int c = a % 9;
        return (((r + c) % 3) == 1) ? sol_dig(a) : 0;
    endfunction

    assign bif.puz_data = (bif.rom_addr < 7'd81) ? 4'(puz_dig(int'(bif.rom_addr))) : 4'd0;
    assign bif.sol_data = (bif.rom_addr < 7'd81) ? 4'(sol_dig(int'(bif.rom_addr))) : 4'd0;

    initial begin
        for (int i = 0; i < 81; i++) ram[i] = 4'd0;
    end

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (bif.brd_we && (bif.brd_addr < 7'd81)) ram[bif.brd_addr] <= bif.brd_wdata;
        bif.brd_rdata <= (bif.brd_addr < 7'd81) ? ram[bif.brd_addr] : 4'd0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_st(input logic [5:0] st, input int lat, input bit ce, input int er, input int ec,
                           input bit cc_en, input int cr, input int cc);
        st_exp_t e;
        e.st = int'(st); e.lat = lat; e.chk_err = ce; e.er = er; e.ec = ec;
        e.chk_cur = cc_en; e.cr = cr; e.cc = cc;
        st_q.push_back(e);
    endtask

    // Monitor: commits in SOLVE and every state change are checked against the queues.
    logic [5:0] prev_st = 6'd0;
    int entry_cyc = 0;
    always @(negedge Clk) begin
        st_exp_t e;
        wr_t w;
        if (q_Solve && bif.brd_we) begin
            nwr++;
            if (wr_q.size() == 0) begin
                chk("unexpected_write_addr", int'(bif.brd_addr), -1);
            end else begin
                w = wr_q.pop_front();
                chk("write_addr", int'(bif.brd_addr), w.addr);
                chk("write_data", int'(bif.brd_wdata), w.data);
            end
        end
        if (st_vec != prev_st) begin
            if (st_q.size() == 0) begin
                chk("unexpected_state", int'(st_vec), 0);
            end else begin
                e = st_q.pop_front();
                chk("state", int'(st_vec), e.st);
                if (e.lat >= 0) chk("cycles_in_prev_state", cyc - entry_cyc, e.lat);
                if (e.chk_err) begin
                    chk("ErrRow", int'(ErrRow), e.er);
                    chk("ErrCol", int'(ErrCol), e.ec);
                end
                if (e.chk_cur) begin
                    chk("CurRow", int'(CurRow), e.cr);
                    chk("CurCol", int'(CurCol), e.cc);
                end
            end
            prev_st = st_vec;
            entry_cyc = cyc;
        end
    end

    task automatic pulse(input logic [6:0] v);
        @(posedge Clk); #1;
        {Ack, CheckSolu, BtnC, BtnD, BtnU, BtnL, BtnR} = v;
        @(posedge Clk); #1;
        {Ack, CheckSolu, BtnC, BtnD, BtnU, BtnL, BtnR} = 7'd0;
    endtask

    task automatic wait_st(input int idx, input int budget, input string nm);
        int n = 0;
        while ((st_vec[idx] !== 1'b1) && (n < budget)) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (st_vec[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s: state bit %0d not reached after %0d cycles", nm, idx, n);
        end
    endtask

    task automatic goto(input int r, input int c);
        for (int k = 0; k < 20; k++) begin
            if (int'(CurRow) < r) pulse(P_D);
            else if (int'(CurRow) > r) pulse(P_U);
            else if (int'(CurCol) < c) pulse(P_R);
            else if (int'(CurCol) > c) pulse(P_L);
            else break;
        end
    endtask

    // Commit the solution into every free cell; cell 'skip' gets 0 instead.
    task automatic fill(input int skip);
        for (int r = 0; r < 9; r++) begin
            for (int j = 0; j < 9; j++) begin
                int c = ((r % 2) == 0) ? j : 8 - j;
                int a = r * 9 + c;
                int d = (a == skip) ? 0 : sol_dig(a);
                if (puz_dig(a) == 0) begin
                    goto(r, c);
                    UserIn = 4'(d);
                    wr_q.push_back('{a, d});
                    pulse(P_C);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        bit found;
        // Reset and initial load.
        push_st(ST_I, -1, 1'b1, 0, 0, 1'b1, 0, 0);
        push_st(ST_LOAD, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_SOLVE, 81, 1'b0, 0, 0, 1'b1, 0, 0);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_brd_we", int'(bif.brd_we), 0);
        Reset = 1'b0;
        wait_st(2, 200, "load_done");
        chk("ram1_loaded", int'(ram[1]), 5);
        chk("ram0_loaded", int'(ram[0]), 0);
        chk("fixed1", int'(dut.fixed_r[1]), 1);
        chk("fixed0", int'(dut.fixed_r[0]), 0);

        // Cursor clamping and move priority.
        pulse(P_L);
        chk("clampL_col", int'(CurCol), 0);
        pulse(P_U);
        chk("clampU_row", int'(CurRow), 0);
        repeat (9) pulse(P_R);
        chk("nineR_col", int'(CurCol), 8);
        pulse(P_L);
        pulse(P_R | P_D);
        chk("RD_col", int'(CurCol), 8);
        chk("RD_row", int'(CurRow), 0);
        repeat (8) pulse(P_L);
        chk("back_col", int'(CurCol), 0);

        // Commit guard.
        UserIn = 4'd2;
        wr_q.push_back('{0, 2});
        pulse(P_C);
        chk("ram0_commit", int'(ram[0]), 2);
        pulse(P_R);
        saved = nwr;
        UserIn = 4'd3;
        pulse(P_C);
        chk("fixed_no_write", nwr, saved);
        chk("ram1_kept", int'(ram[1]), 5);
        pulse(P_R);
        UserIn = 4'd12;
        pulse(P_C);
        chk("digit12_no_write", nwr, saved);

        // Incorrect: all solved except cell 40 left empty.
        fill(40);
        push_st(ST_CHECK, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_INCORRECT, 42, 1'b1, 4, 4, 1'b0, 0, 0);
        pulse(P_CHK);
        wait_st(5, 100, "incorrect");
        push_st(ST_SOLVE, -1, 1'b1, 4, 4, 1'b1, 4, 4);
        pulse(P_ACK);
        wait_st(2, 10, "solve_after_ack");

        // Correct: complete cell 40 with its solution digit 3.
        UserIn = 4'd3;
        wr_q.push_back('{40, 3});
        pulse(P_C);
        push_st(ST_CHECK, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_CORRECT, 82, 1'b0, 0, 0, 1'b0, 0, 0);
        pulse(P_CHK);
        wait_st(4, 120, "correct");
        push_st(ST_I, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_LOAD, 1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_SOLVE, 81, 1'b0, 0, 0, 1'b0, 0, 0);
        pulse(P_ACK);
        wait_st(2, 200, "reload_after_correct");
        chk("reload_ram0", int'(ram[0]), 0);
        chk("reload_ram40", int'(ram[40]), 0);

        // Async reset in the middle of a check scan.
        fill(-1);
        push_st(ST_CHECK, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        pulse(P_CHK);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge Clk);
            if (q_Check && (bif.brd_addr == 7'd30)) found = 1'b1;
        end
        chk("scan_reached_30", int'(found), 1);
        push_st(ST_I, -1, 1'b1, 0, 0, 1'b1, 0, 0);
        push_st(ST_LOAD, -1, 1'b0, 0, 0, 1'b0, 0, 0);
        push_st(ST_SOLVE, 81, 1'b0, 0, 0, 1'b0, 0, 0);
        #2 Reset = 1'b1;
        #1;
        chk("midcheck_q_I", int'(q_I), 1);
        chk("midcheck_q_Check", int'(q_Check), 0);
        chk("midcheck_brd_we", int'(bif.brd_we), 0);
        chk("midcheck_cursor", int'(CurRow) * 16 + int'(CurCol), 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        wait_st(2, 200, "reload_after_reset");
        chk("rst_reload_ram0", int'(ram[0]), 0);
        chk("rst_reload_ram1", int'(ram[1]), 5);
        chk("rst_fixed1", int'(dut.fixed_r[1]), 1);

        repeat (3) @(posedge Clk);
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("st_queue_empty", st_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sindoku_game_ctrl.md
Name: sindoku_game_ctrl

Overview:
- Game sequencer for the Sudoku board datapath, sitting between the debounced Nexys-4 button pulses and a single-port 81-entry board RAM.
- Loads a puzzle from the puzzle ROM and keeps a mask of fixed (given) cells.
- Moves a clamped cursor and writes user digits into non-fixed cells only.
- On request, scans the board against the solution ROM, one cell per cycle, and reports correct or the first wrong cell.

Parameters:
- GRID, 9, board side; only 9 is supported.
- CELLS, 81, GRID*GRID.
- AW, 7, board/ROM address width.
- DW, 4, digit width; 0 means an empty cell.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- BtnR, BtnL, BtnU, BtnD, BtnC  in  1 each  single-cycle debounced pulses: move cursor right/left/up/down, commit digit.
- CheckSolu  in  1  pulse: start the check scan.
- Ack  in  1  pulse: acknowledge a result.
- UserIn  in  DW  digit to commit.
- rom_addr  out  AW  address to the puzzle ROM and solution ROM (both combinational).
- puz_data  in  DW  given digit at rom_addr, 0 means blank.
- sol_data  in  DW  solution digit at rom_addr.
- brd_addr  out  AW  board RAM address.
- brd_we  out  1  board RAM write strobe.
- brd_wdata  out  DW  board RAM write data.
- brd_rdata  in  DW  board RAM read data, one-cycle latency.
- CurRow, CurCol  out  4 each  cursor position, 0..8.
- ErrRow, ErrCol  out  4 each  first mismatching cell of the last check.
- q_I, q_Load, q_Solve, q_Check, q_Correct, q_Incorrect  out  1 each  one-hot state outputs.

Behaviour:
- Address rule: addr = row*9 + col, 0..80.
- State register is one-hot, 6 bits: I, LOAD, SOLVE, CHECK, CORRECT, INCORRECT.
- Reset (async, any time, including mid-LOAD or mid-CHECK):
  - state=I; cursor=(0,0); ErrRow=ErrCol=0.
  - scan counter=0; fixed mask=all 0; brd_we=0.
- I: next cycle goes to LOAD with counter=0.
- LOAD, counter k = 0..80:
  - rom_addr=brd_addr=k, brd_we=1, brd_wdata=puz_data.
  - fixed[k] <= (puz_data!=0).
  - After k=80 goes to SOLVE; LOAD lasts exactly 81 cycles.
  - All buttons are ignored in LOAD.
- SOLVE: exactly one action per cycle, priority CheckSolu > BtnC > BtnR > BtnL > BtnU > BtnD.
  - CheckSolu: go to CHECK, counter=0.
  - BtnC: if fixed[cursor]==0 and UserIn<=9, then brd_we=1 at the cursor address with brd_wdata=UserIn (0 clears the cell). Otherwise no write.
  - R/L/U/D: move one step; clamp at 0 and 8, no wrap-around.
  - brd_we is 0 in every cycle without a legal commit.
- CHECK, two-stage pipeline:
  - Cycle t (t=0..80) drives rom_addr=brd_addr=t and registers sol_data.
  - Cycle t+1 compares brd_rdata against the registered solution for address t.
  - On the first mismatch at address t: ErrRow/ErrCol <= coordinates of t; state becomes INCORRECT, visible at cycle t+2 after CHECK entry. Remaining cells are not compared.
  - Empty cells (0) count as mismatches.
  - All cells match: CORRECT, visible at cycle 82 after CHECK entry.
  - Buttons and CheckSolu are ignored in CHECK.
- CORRECT: holds until Ack, then goes to I, which reloads the board.
- INCORRECT: holds until Ack, then goes to SOLVE. Cursor <= (ErrRow, ErrCol); the board is kept.
- Ack is ignored outside CORRECT and INCORRECT.
- Illegal one-hot state: go to I.
- Cursor and ErrRow/ErrCol are registered outputs; rom_addr, brd_addr, brd_we and brd_wdata are combinational from state, counter and cursor.

Decomposition:
- Package sindoku_pkg holds:
  - GRID, CELLS, AW, DW constants.
  - The six one-hot state encodings.
  - A function rc2addr(row, col).
- One sub-module, sindoku_cursor: row/col registers, clamped moves, priority decode of R/L/U/D, load-from-error input, combinational linear address output.

Test Plan:
- Load: Reset, release; puzzle ROM cell 0=0, cell 1=5. After 81 LOAD cycles: q_Solve=1, RAM[1]=5, fixed[1]=1, fixed[0]=0.
- Cursor clamp: BtnL and BtnU at (0,0) leave the cursor at (0,0). Nine BtnR then CurCol=8. Simultaneous BtnR+BtnD moves right only.
- Commit guard:
  - Cursor (0,0), UserIn=2, BtnC: write to addr 0 with data 2.
  - Cursor (0,1) (fixed), BtnC: no write.
  - UserIn=12 on a free cell: no write.
- Incorrect: board fully solved except addr 40 = 0. CheckSolu: q_Incorrect asserts 42 cycles after CHECK entry, ErrRow=4, ErrCol=4. Ack gives SOLVE with cursor (4,4).
- Correct: fill all cells with the solution, CheckSolu: q_Correct asserts 82 cycles after CHECK entry. Ack gives I then LOAD.
- Async reset mid-CHECK at scan address 30: immediately q_I=1, brd_we=0, then a full reload follows.
